// File: rtl/mac_frame_ctrl.sv
// Frame controller for a never-cleared fixed-point MAC: forwards framed operand
// pairs, tracks beats in flight and emits one baseline-corrected sum per frame.
module mac_frame_ctrl #(
  parameter int int_in_p      = 1,
  parameter int frac_in_p     = 11,
  parameter int int_out_p     = 10,
  parameter int frac_out_p    = 22,
  parameter int count_width_p = 16
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [int_in_p+frac_in_p-1:0]     a_i,
  input  logic [int_in_p+frac_in_p-1:0]     b_i,
  input  logic                              last_i,
  input  logic                              valid_i,
  output logic                              ready_o,
  output logic [int_in_p+frac_in_p-1:0]     mac_a_o,
  output logic [int_in_p+frac_in_p-1:0]     mac_b_o,
  output logic                              mac_valid_o,
  input  logic                              mac_ready_i,
  input  logic                              mac_valid_i,
  input  logic [int_out_p+frac_out_p-1:0]   mac_data_i,
  output logic                              mac_ready_o,
  output logic [int_out_p+frac_out_p-1:0]   sum_o,
  output logic [count_width_p-1:0]          count_o,
  output logic                              valid_o,
  input  logic                              ready_i
);

  localparam int out_w_lp = int_out_p + frac_out_p;
  localparam logic [count_width_p-1:0] one_lp = count_width_p'(1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t                     state_r;
  state_t                     state_s;
  logic [count_width_p-1:0]   beat_r;
  logic [count_width_p-1:0]   outst_r;
  logic [out_w_lp-1:0]        base_r;
  logic [out_w_lp-1:0]        sum_r;
  logic [count_width_p-1:0]   count_r;
  logic                       valid_r;

  logic                       run_s;
  logic                       accept_s;
  logic                       retire_s;
  logic                       done_s;
  logic                       release_s;

  // Handshake decode and next-state selection.
  always_comb begin
    run_s     = (state_r == ST_RUN);
    accept_s  = valid_i && mac_ready_i && run_s;
    // Guarding against an empty counter keeps a spurious MAC strobe from underflowing it.
    retire_s  = mac_valid_i && (outst_r != '0);
    done_s    = (state_r == ST_DRAIN) && mac_valid_i && (outst_r == one_lp);
    release_s = (state_r == ST_HOLD) && ready_i;
    state_s   = state_r;
    case (state_r)
      ST_RUN: begin
        if (accept_s && last_i) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (done_s) begin
          state_s = ST_HOLD;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_HOLD: begin
        if (ready_i) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_HOLD;
        end
      end
      default: state_s = ST_RUN;
    endcase
  end

  // State, counters, baseline and registered result.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= ST_RUN;
      beat_r  <= '0;
      outst_r <= '0;
      base_r  <= '0;
      sum_r   <= '0;
      count_r <= '0;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_s;

      case ({accept_s, retire_s})
        2'b10:   outst_r <= outst_r + one_lp;
        2'b01:   outst_r <= outst_r - one_lp;
        default: outst_r <= outst_r;
      endcase

      if (release_s) begin
        beat_r <= '0;
      end else if (accept_s) begin
        beat_r <= beat_r + one_lp;
      end else begin
        beat_r <= beat_r;
      end

      // Modular subtraction recovers the frame sum even across accumulator wrap.
      if (done_s) begin
        sum_r   <= mac_data_i - base_r;
        base_r  <= mac_data_i;
        count_r <= beat_r;
        valid_r <= 1'b1;
      end else if (release_s) begin
        valid_r <= 1'b0;
      end else begin
        valid_r <= valid_r;
      end
    end
  end

  assign mac_a_o     = a_i;
  assign mac_b_o     = b_i;
  assign mac_valid_o = valid_i && run_s;
  assign ready_o     = mac_ready_i && run_s;
  assign mac_ready_o = 1'b1;
  assign sum_o       = sum_r;
  assign count_o     = count_r;
  assign valid_o     = valid_r;

endmodule

// File: tb/tb_mac_frame_ctrl.sv
// Self-checking bench for mac_frame_ctrl: latency-1 MAC stub plus a frame-level
// model (sum of products per frame) compared against the DUT every cycle.
module tb_mac_frame_ctrl;

  localparam int IW = 12;
  localparam int OW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset_i;
  logic [IW-1:0] a_i, b_i;
  logic          last_i, valid_i, ready_o;
  logic [IW-1:0] mac_a_o, mac_b_o;
  logic          mac_valid_o, mac_ready_i, mac_valid_i;
  logic [OW-1:0] mac_data_i;
  logic          mac_ready_o;
  logic [OW-1:0] sum_o;
  logic [CW-1:0] count_o;
  logic          valid_o, ready_i;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mac_frame_ctrl dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .a_i        (a_i),
    .b_i        (b_i),
    .last_i     (last_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .mac_a_o    (mac_a_o),
    .mac_b_o    (mac_b_o),
    .mac_valid_o(mac_valid_o),
    .mac_ready_i(mac_ready_i),
    .mac_valid_i(mac_valid_i),
    .mac_data_i (mac_data_i),
    .mac_ready_o(mac_ready_o),
    .sum_o      (sum_o),
    .count_o    (count_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i)
  );

  // Q1.11 x Q1.11 -> Q2.22, sign-extended into the Q10.22 accumulator width.
  function automatic logic [OW-1:0] prod(input logic [IW-1:0] a, input logic [IW-1:0] b);
    logic signed [2*IW-1:0] p;
    logic signed [OW-1:0]   r;
    p = $signed(a) * $signed(b);
    r = p;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // MAC stub: accumulator shares the controller's reset, one cycle latency.
  logic [OW-1:0] mac_acc;
  always @(posedge clk) begin
    if (reset_i) begin
      mac_acc     <= '0;
      mac_valid_i <= 1'b0;
    end else if (mac_valid_o && mac_ready_i) begin
      mac_acc     <= mac_acc + prod(mac_a_o, mac_b_o);
      mac_valid_i <= 1'b1;
    end else begin
      mac_valid_i <= 1'b0;
    end
  end
  assign mac_data_i = mac_acc;

  // Frame-level model state (describes the cycle following the current negedge).
  logic          m_stall = 1'b0;
  logic          m_valid = 1'b0;
  logic [OW-1:0] m_sum = '0;
  logic [CW-1:0] m_cnt = '0;
  logic [OW-1:0] m_fsum = '0;
  logic [CW-1:0] m_beats = '0;
  logic [OW-1:0] m_pend = '0;
  logic [CW-1:0] m_pend_cnt = '0;
  logic          m_timer = 1'b0;

  initial begin : compare
    logic acc;
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("valid_o", valid_o, m_valid);
      chk("sum_o", sum_o, m_sum);
      chk("count_o", count_o, m_cnt);
      chk("ready_o", ready_o, mac_ready_i && !m_stall);
      chk("mac_valid_o", mac_valid_o, valid_i && !m_stall);
      chk("mac_a_o", mac_a_o, a_i);
      chk("mac_b_o", mac_b_o, b_i);
      chk("mac_ready_o", mac_ready_o, 1'b1);
      if (reset_i) begin
        m_stall = 1'b0; m_valid = 1'b0; m_sum = '0; m_cnt = '0;
        m_fsum = '0; m_beats = '0; m_timer = 1'b0;
      end else begin
        acc = valid_i && mac_ready_i && !m_stall;
        if (m_timer) begin
          m_valid = 1'b1; m_sum = m_pend; m_cnt = m_pend_cnt; m_timer = 1'b0;
        end else if (m_valid && ready_i) begin
          m_valid = 1'b0; m_stall = 1'b0;
        end
        if (acc) begin
          m_fsum  = m_fsum + prod(a_i, b_i);
          m_beats = m_beats + 16'd1;
          if (last_i) begin
            m_stall = 1'b1; m_timer = 1'b1;
            m_pend = m_fsum; m_pend_cnt = m_beats;
            m_fsum = '0; m_beats = '0;
          end
        end
      end
    end
  end

  task automatic send(input logic [IW-1:0] a, input logic [IW-1:0] b, input logic last);
    int n;
    n = 0;
    a_i = a; b_i = b; last_i = last; valid_i = 1'b1;
    @(negedge clk);
    while (!ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", ready_o, 1'b1);
    @(posedge clk); #1;
    valid_i = 1'b0; last_i = 1'b0;
  endtask

  task automatic idle();
    valid_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!valid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(nm, valid_o, 1'b1);
  endtask

  task automatic take_result(input string nm, input logic [OW-1:0] s, input logic [CW-1:0] c);
    wait_valid(nm);
    chk({nm, "_sum"}, sum_o, s);
    chk({nm, "_cnt"}, count_o, c);
    @(posedge clk); #1 ready_i = 1'b1;
    @(posedge clk); #1 ready_i = 1'b0;
  endtask

  task automatic post_reset_checks(input string nm);
    @(negedge clk);
    chk({nm, "_valid"}, valid_o, 1'b0);
    chk({nm, "_ready"}, ready_o, 1'b1);
    chk({nm, "_sum"}, sum_o, 32'h0);
    chk({nm, "_cnt"}, count_o, 16'h0);
  endtask

  localparam logic [IW-1:0] HALF = 12'h400;
  localparam logic [IW-1:0] NEG1 = 12'h800;

  initial begin : stim
    reset_i = 1'b1; valid_i = 1'b0; last_i = 1'b0; a_i = '0; b_i = '0;
    mac_ready_i = 1'b1; ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_i = 1'b0;
    post_reset_checks("reset");
    @(posedge clk); #1;

    // Frame 1: 4 x 0.25 = 1.0, valid two cycles after last acceptance.
    repeat (3) send(HALF, HALF, 1'b0);
    send(HALF, HALF, 1'b1);
    @(negedge clk); chk("lat_t1", valid_o, 1'b0);
    @(negedge clk); chk("lat_t2", valid_o, 1'b1);
    chk("f1_sum_lit", sum_o, 32'h0040_0000);
    chk("f1_cnt_lit", count_o, 16'd4);
    take_result("f1", 32'h0040_0000, 16'd4);

    // Frame 2 back-to-back: 3 x -0.5 = -1.5 against baseline 1.0.
    repeat (2) send(NEG1, HALF, 1'b0);
    send(NEG1, HALF, 1'b1);
    take_result("f2", 32'hFFA0_0000, 16'd3);

    send(HALF, HALF, 1'b1);
    take_result("single", 32'h0010_0000, 16'd1);

    // Backpressure in HOLD with an offered beat.
    send(HALF, HALF, 1'b1);
    wait_valid("bp_wait");
    @(posedge clk); #1;
    a_i = HALF; b_i = HALF; last_i = 1'b1; valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", valid_o, 1'b1);
      chk("bp_ready", ready_o, 1'b0);
      chk("bp_macvalid", mac_valid_o, 1'b0);
      chk("bp_sum", sum_o, 32'h0010_0000);
      chk("bp_cnt", count_o, 16'd1);
    end
    @(posedge clk); #1 ready_i = 1'b1;
    @(posedge clk); #1 ready_i = 1'b0;
    @(negedge clk); chk("bp_accept", ready_o, 1'b1);
    @(posedge clk); #1 valid_i = 1'b0; last_i = 1'b0;
    take_result("bp_next", 32'h0010_0000, 16'd1);

    // Gapped frame including a MAC-side stall.
    send(HALF, HALF, 1'b0);
    idle();
    a_i = HALF; b_i = HALF; valid_i = 1'b1; mac_ready_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mac_ready_i = 1'b1;
    send(HALF, HALF, 1'b0);
    idle();
    send(HALF, HALF, 1'b0);
    idle(); idle();
    send(HALF, HALF, 1'b1);
    take_result("gaps", 32'h0040_0000, 16'd4);

    // Reset while draining.
    send(HALF, HALF, 1'b0);
    send(HALF, HALF, 1'b1);
    reset_i = 1'b1;
    @(posedge clk); #1 reset_i = 1'b0;
    post_reset_checks("rst_drain");
    @(posedge clk); #1;
    send(HALF, HALF, 1'b1);
    take_result("after_drain", 32'h0010_0000, 16'd1);

    // Reset while holding a result.
    send(NEG1, HALF, 1'b0);
    send(HALF, HALF, 1'b1);
    wait_valid("hold_wait");
    @(posedge clk); #1 reset_i = 1'b1;
    @(posedge clk); #1 reset_i = 1'b0;
    post_reset_checks("rst_hold");
    @(posedge clk); #1;
    send(HALF, HALF, 1'b1);
    take_result("after_hold", 32'h0010_0000, 16'd1);

    repeat (3) idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
